// File: rtl/aes_inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: BPC bytes per cycle through InvSbox, result held for a valid/ready consumer.
// Optional macro AES_INV_SUB_SELFCHECK_EN re-applies the forward S-box per chunk and flags mismatches on check_err.
module aes_inv_sub_bytes_seq #(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic         check_err
);
  localparam int NCHUNK = 16 / BPC;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  // Entry b lives at [8*b +: 8] (ascending range, first row first).
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  if (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8 && BPC != 16) begin : g_bad_bpc
    $error("aes_inv_sub_bytes_seq: BPC must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [127:0]  work, work_nxt;
  logic [6:0]    pos;
  logic          accept, last;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  assign accept = in_valid && (state == IDLE);
  assign last   = (cnt == LAST);

`ifdef AES_INV_SUB_SELFCHECK_EN
  localparam logic [0:2047] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [127:0] orig;
  logic         mism;

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    return FWD_SBOX[{b, 3'b000} +: 8];
  endfunction
`endif

  always_comb begin
    work_nxt = work;
    pos      = '0;
`ifdef AES_INV_SUB_SELFCHECK_EN
    mism     = 1'b0;
`endif
    for (int unsigned j = 0; j < BPC; j++) begin
      // byte index cnt*BPC+j; byte0 sits in the top bits
      pos = 7'(120 - 8 * (32'(cnt) * BPC + j));
      work_nxt[pos +: 8] = inv_sbox(work[pos +: 8]);
`ifdef AES_INV_SUB_SELFCHECK_EN
      if (fwd_sbox(work_nxt[pos +: 8]) != orig[pos +: 8]) mism = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = BUSY;
      BUSY:    if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // out_state is a separate register so partial work never shows on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      work      <= '0;
      out_state <= '0;
    end else if (accept) begin
      work <= in_state;
      cnt  <= '0;
    end else if (state == BUSY) begin
      work <= work_nxt;
      cnt  <= last ? '0 : cnt + 1'b1;
      if (last) out_state <= work_nxt;
    end
  end

`ifdef AES_INV_SUB_SELFCHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orig      <= '0;
      check_err <= 1'b0;
    end else if (accept) begin
      orig      <= in_state;
      check_err <= 1'b0;
    end else if (state == BUSY && mism) begin
      check_err <= 1'b1;
    end
  end
`else
  assign check_err = 1'b0;
`endif

endmodule
